// File: rtl/pipe_sched_pkg.sv
// Shared types and constants for the pipe scheduler.
// FSM states, LFSR seed/taps and score saturation helper.
package pipe_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SPAWN,
    CHECK,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [9:0]  SCORE_MAX = 10'd999;

  function automatic logic [9:0] score_add(
    input logic [9:0] s,
    input logic [1:0] n
  );
    logic [10:0] t;
    t = {1'b0, s} + {9'b0, n};
    return (t > {1'b0, SCORE_MAX}) ? SCORE_MAX : t[9:0];
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Fibonacci LFSR for pipe gap heights.
// Steps once per accepted frame; reseeds only on rst.
module pipe_lfsr
  import pipe_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= LFSR_SEED;
    else if (step)
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe scheduler: scrolls, spawns, scores and collides three pipe slots.
// Define PIPE_SCHED_LFSR_EN for LFSR gaps instead of a 4-step gap cycle.
module pipe_scheduler
  import pipe_sched_pkg::*;
#(
  parameter int SPEED        = 5,
  parameter int SPAWN_PERIOD = 64,
  parameter int SPAWN_SCROLL = 480,
  parameter int BIRD_SCROLL  = 100,
  parameter int PIPE_W       = 52,
  parameter int BIRD_W       = 34,
  parameter int GAP_H        = 160,
  parameter int GAP_BASE     = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               run,
  input  logic               clear,
  input  logic signed [15:0] bird_gap,
  output logic signed [15:0] pipe1_scroll,
  output logic signed [15:0] pipe1_gap,
  output logic signed [15:0] pipe2_scroll,
  output logic signed [15:0] pipe2_gap,
  output logic signed [15:0] pipe3_scroll,
  output logic signed [15:0] pipe3_gap,
  output logic [2:0]         pipe_valid,
  output logic [9:0]         score,
  output logic               hit,
  output logic               busy,
  output logic               done
);

  localparam int FCW = $clog2(SPAWN_PERIOD);
  localparam logic [FCW-1:0] FC_LAST = FCW'(SPAWN_PERIOD - 1);

  localparam logic signed [15:0] SPD      = 16'(SPEED);
  localparam logic signed [15:0] BS       = 16'(BIRD_SCROLL);
  localparam logic signed [15:0] HIT_LO   = 16'(BIRD_SCROLL - PIPE_W);
  localparam logic signed [15:0] HIT_HI   = 16'(BIRD_SCROLL + BIRD_W);
  localparam logic signed [15:0] GAP_SPAN = 16'(GAP_H - BIRD_W);
  localparam logic signed [15:0] OFF_LO   = 16'(-PIPE_W);
  localparam logic signed [15:0] SPAWN_S  = 16'(SPAWN_SCROLL);
  localparam logic signed [15:0] GB       = 16'(GAP_BASE);
  localparam logic signed [15:0] RST_S    = -16'sd120;

  state_t state, next;

  logic signed [15:0] scroll_q [3];
  logic signed [15:0] gap_q    [3];
  logic [2:0]         valid_q;
  logic [2:0]         cross_q;
  logic [2:0]         crossing;
  logic [2:0]         collide;
  logic [2:0]         gone;
  logic [1:0]         pass_cnt;
  logic               spawn_q;
  logic [FCW-1:0]     fc_q;
  logic [9:0]         score_q;
  logic               hit_q;
  logic               accept;
  logic signed [15:0] new_gap;

  assign accept = (state == IDLE) && frame_tick && run && !hit_q;

`ifdef PIPE_SCHED_LFSR_EN
  logic [15:0] lfsr;

  pipe_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (accept && !clear),
    .lfsr (lfsr)
  );

  assign new_gap = GB + {8'h00, lfsr[7:0]};
`else
  logic [1:0] k_q;

  always_ff @(posedge clk) begin
    if (rst)
      k_q <= '0;
    else if (state == SPAWN && spawn_q && !clear)
      k_q <= k_q + 2'd1;
  end

  assign new_gap = GB + {8'h00, k_q, 6'h00};
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (accept) next = SHIFT;
      SHIFT:   next = SPAWN;
      SPAWN:   next = CHECK;
      CHECK:   next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    if (clear)
      next = IDLE;
  end

  // crossing is judged at SHIFT on the pre/post scroll of each slot
  always_comb begin
    crossing = '0;
    collide  = '0;
    gone     = '0;
    for (int i = 0; i < 3; i++) begin
      crossing[i] = valid_q[i] && (scroll_q[i] >= BS)
                    && ((scroll_q[i] - SPD) < BS);
      collide[i]  = valid_q[i]
                    && (scroll_q[i] > HIT_LO) && (scroll_q[i] < HIT_HI)
                    && ((bird_gap < gap_q[i])
                        || (bird_gap > gap_q[i] + GAP_SPAN));
      gone[i]     = valid_q[i] && (scroll_q[i] < OFF_LO);
    end
    pass_cnt = {1'b0, cross_q[0] & valid_q[0]}
             + {1'b0, cross_q[1] & valid_q[1]}
             + {1'b0, cross_q[2] & valid_q[2]};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 3; i++) begin
        scroll_q[i] <= RST_S;
        gap_q[i]    <= GB;
      end
      valid_q <= '0;
      cross_q <= '0;
      spawn_q <= 1'b0;
      fc_q    <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          for (int i = 0; i < 3; i++)
            if (valid_q[i])
              scroll_q[i] <= scroll_q[i] - SPD;
          cross_q <= crossing;
          spawn_q <= (fc_q == '0);
          fc_q    <= (fc_q == FC_LAST) ? '0 : fc_q + FCW'(1);
        end
        SPAWN: begin
          if (spawn_q) begin
            scroll_q[0] <= scroll_q[1];
            scroll_q[1] <= scroll_q[2];
            scroll_q[2] <= SPAWN_S;
            gap_q[0]    <= gap_q[1];
            gap_q[1]    <= gap_q[2];
            gap_q[2]    <= new_gap;
            valid_q     <= {1'b1, valid_q[2:1]};
            cross_q     <= {1'b0, cross_q[2:1]};
          end
        end
        CHECK: begin
          score_q <= score_add(score_q, pass_cnt);
          if (|collide)
            hit_q <= 1'b1;
          valid_q <= valid_q & ~gone;
        end
        default: ;
      endcase
    end
  end

  assign pipe1_scroll = scroll_q[0];
  assign pipe2_scroll = scroll_q[1];
  assign pipe3_scroll = scroll_q[2];
  assign pipe1_gap    = gap_q[0];
  assign pipe2_gap    = gap_q[1];
  assign pipe3_gap    = gap_q[2];
  assign pipe_valid   = valid_q;
  assign score        = score_q;
  assign hit          = hit_q;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_pipe_scheduler.sv
// Self-checking bench for pipe_scheduler (default build, counter gaps).
// Frame-level reference model plus table vectors and corner sequences.
module tb_pipe_scheduler;

  logic clk = 1'b0;
  logic rst, frame_tick, run, clear;
  logic signed [15:0] bird_gap;
  logic signed [15:0] p1s, p1g, p2s, p2g, p3s, p3g;
  logic [2:0] pipe_valid;
  logic [9:0] score;
  logic hit, busy, done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .run          (run),
    .clear        (clear),
    .bird_gap     (bird_gap),
    .pipe1_scroll (p1s),
    .pipe1_gap    (p1g),
    .pipe2_scroll (p2s),
    .pipe2_gap    (p2g),
    .pipe3_scroll (p3s),
    .pipe3_gap    (p3g),
    .pipe_valid   (pipe_valid),
    .score        (score),
    .hit          (hit),
    .busy         (busy),
    .done         (done)
  );

  // frame-level reference model
  int m_scr [3];
  int m_gap [3];
  bit m_val [3];
  int m_score, m_frames, m_k;
  bit m_hit;

  function automatic void m_reset(bit full);
    for (int i = 0; i < 3; i++) begin
      m_scr[i] = -120;
      m_gap[i] = 200;
      m_val[i] = 0;
    end
    m_score  = 0;
    m_hit    = 0;
    m_frames = 0;
    if (full) m_k = 0;
  endfunction

  function automatic bit m_frame(bit r, int bg);
    bit crossed [3];
    int pre;
    if (!r || m_hit) return 0;
    for (int i = 0; i < 3; i++) begin
      crossed[i] = 0;
      if (m_val[i]) begin
        pre = m_scr[i];
        m_scr[i] = m_scr[i] - 5;
        crossed[i] = (pre >= 100) && (m_scr[i] < 100);
      end
    end
    if (m_frames % 64 == 0) begin
      for (int i = 0; i < 2; i++) begin
        m_scr[i] = m_scr[i+1];
        m_gap[i] = m_gap[i+1];
        m_val[i] = m_val[i+1];
        crossed[i] = crossed[i+1];
      end
      m_scr[2] = 480;
      m_gap[2] = 200 + 64 * (m_k % 4);
      m_val[2] = 1;
      crossed[2] = 0;
      m_k++;
    end
    m_frames++;
    for (int i = 0; i < 3; i++) begin
      if (m_val[i]) begin
        if (crossed[i] && m_score < 999) m_score++;
        if (m_scr[i] > 48 && m_scr[i] < 134 &&
            (bg < m_gap[i] || bg > m_gap[i] + 126))
          m_hit = 1;
        if (m_scr[i] < -52) m_val[i] = 0;
      end
    end
    return 1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic state_chk(string nm);
    chk({nm, " p1_scroll"}, int'(p1s), m_scr[0]);
    chk({nm, " p2_scroll"}, int'(p2s), m_scr[1]);
    chk({nm, " p3_scroll"}, int'(p3s), m_scr[2]);
    chk({nm, " p1_gap"}, int'(p1g), m_gap[0]);
    chk({nm, " p2_gap"}, int'(p2g), m_gap[1]);
    chk({nm, " p3_gap"}, int'(p3g), m_gap[2]);
    chk({nm, " valid"}, int'(pipe_valid),
        int'({m_val[2], m_val[1], m_val[0]}));
    chk({nm, " score"}, int'(score), m_score);
    chk({nm, " hit"}, int'(hit), int'(m_hit));
    chk({nm, " busy"}, int'(busy), 0);
  endtask

  task automatic frame(bit r, int bg, output int lat, output int nd,
                       output int b1);
    @(negedge clk);
    run = r;
    bird_gap = 16'(bg);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    lat = -1;
    nd = 0;
    b1 = int'(busy);
    for (int c = 1; c <= 8; c++) begin
      if (done) begin
        nd++;
        if (lat < 0) lat = c;
      end
      if (c < 8) @(negedge clk);
    end
  endtask

  task automatic frame_chk(string nm, bit r, int bg);
    int lat, nd, b1;
    bit acc;
    acc = m_frame(r, bg);
    frame(r, bg, lat, nd, b1);
    chk({nm, " done_lat"}, lat, acc ? 4 : -1);
    chk({nm, " done_cnt"}, nd, acc ? 1 : 0);
    chk({nm, " busy_early"}, b1, acc ? 1 : 0);
    state_chk(nm);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    clear = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset(1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_reset(0);
  endtask

  typedef struct {
    bit run;
    int bg;
    int e_nd;
    int e_valid;
    int e_p3s;
    int e_p3g;
    int e_score;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat, nd, b1, bg, sel;

    tbl[0] = '{0, 260, 0, 0, -120, 200, 0};
    tbl[1] = '{1, 260, 1, 4,  480, 200, 0};
    tbl[2] = '{1, 260, 1, 4,  475, 200, 0};
    tbl[3] = '{0, 260, 0, 4,  475, 200, 0};
    tbl[4] = '{1, 260, 1, 4,  470, 200, 0};
    tbl[5] = '{1,   0, 1, 4,  465, 200, 0};

    rst = 1'b1;
    frame_tick = 1'b0;
    run = 1'b0;
    clear = 1'b0;
    bird_gap = '0;

    do_rst();
    chk("reset done", int'(done), 0);
    state_chk("reset");
    do_clear();
    state_chk("clear");

    for (int i = 0; i < 6; i++) begin
      void'(m_frame(tbl[i].run, tbl[i].bg));
      frame(tbl[i].run, tbl[i].bg, lat, nd, b1);
      chk($sformatf("tbl%0d done_cnt", i), nd, tbl[i].e_nd);
      chk($sformatf("tbl%0d done_lat", i), lat, tbl[i].e_nd ? 4 : -1);
      chk($sformatf("tbl%0d valid", i), int'(pipe_valid), tbl[i].e_valid);
      chk($sformatf("tbl%0d p3_scroll", i), int'(p3s), tbl[i].e_p3s);
      chk($sformatf("tbl%0d p3_gap", i), int'(p3g), tbl[i].e_p3g);
      chk($sformatf("tbl%0d score", i), int'(score), tbl[i].e_score);
    end

    // pass one pipe cleanly, then collide
    do_rst();
    for (int f = 1; f <= 78; f++)
      frame_chk($sformatf("pass f%0d", f), 1'b1, 260);
    chk("pass p2_scroll", int'(p2s), 95);
    chk("pass p3_scroll", int'(p3s), 415);
    chk("pass p3_gap", int'(p3g), 264);
    chk("pass valid", int'(pipe_valid), 6);
    chk("pass score", int'(score), 1);
    chk("pass hit", int'(hit), 0);
    frame_chk("collide", 1'b1, 180);
    chk("collide hit", int'(hit), 1);
    chk("collide p2_scroll", int'(p2s), 90);
    frame_chk("frozen1", 1'b1, 260);
    frame_chk("frozen2", 1'b1, 260);
    chk("frozen p2_scroll", int'(p2s), 90);
    do_clear();
    state_chk("post_hit clear");

    // second tick during SHIFT is dropped
    void'(m_frame(1'b1, 260));
    @(negedge clk);
    run = 1'b1;
    bird_gap = 16'sd260;
    frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("tick_in_shift done_cnt", nd, 1);
    state_chk("tick_in_shift");
    frame_chk("after_shift_tick", 1'b1, 260);

    // clear arriving while in SPAWN aborts the update
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_reset(0);
    chk("clr_spawn busy", int'(busy), 0);
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("clr_spawn done_cnt", nd, 0);
    state_chk("clr_spawn");

    // score saturation at 999
    @(negedge clk);
    force dut.score_q = 10'd999;
    @(negedge clk);
    release dut.score_q;
    m_score = 999;
    chk("sat preload", int'(score), 999);
    bg = 200 + 64 * (m_k % 4) + 60;
    for (int f = 1; f <= 78; f++)
      frame_chk($sformatf("sat f%0d", f), 1'b1, bg);
    chk("sat score", int'(score), 999);
    chk("sat hit", int'(hit), 0);

    // randomized frames against the model
    do_rst();
    for (int f = 0; f < 400; f++) begin
      if (m_hit && $urandom_range(0, 3) == 0) begin
        do_clear();
        state_chk($sformatf("rnd clr%0d", f));
      end else begin
        sel = $urandom_range(0, 3);
        bg = (sel < 3) ? 330 : int'($urandom_range(150, 550));
        frame_chk($sformatf("rnd f%0d", f),
                  ($urandom_range(0, 9) != 0), bg);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
